skew_accum_bank: RTL and testbench

- Parametrised successor to the systolic-array output accumulator: one accumulator column per array column, each holding DEPTH row accumulators.
- Takes the column-skewed partial-sum stream, accumulates over K passes with init/overwrite and optional saturation, then drains the finished tile row by row over a valid/ready handshake.
- Sits between the PE array outputs and the requantise/write-back stage.

---
 rtl/skew_accum_pkg.sv | 43 ++++
 rtl/skew_accum_column.sv | 66 ++++++
 rtl/skew_accum_bank.sv | 111 +++++++++++
 tb/tb_skew_accum_bank.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/skew_accum_pkg.sv
// rtl/skew_accum_pkg.sv - shared types and saturating adder for the skewed accumulator bank
package skew_accum_pkg;

    localparam int ROW_W_MAX = 8;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                 valid;
        logic                 init;
        logic [ROW_W_MAX-1:0] row;
    } skew_ctl_t;

    typedef struct packed {
        logic        ovf;
        logic [63:0] sum;
    } sat_res_t;

    // Operands arrive sign-extended from 'width' bits, so the 64-bit sum is exact for width <= 62.
    function automatic sat_res_t sat_add(input logic signed [63:0] a, input logic signed [63:0] b,
                                         input int width, input logic saturate);
        sat_res_t          r;
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s     = a + b;
        hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.ovf = (s > hi) || (s < lo);
        if (!r.ovf)
            r.sum = s;
        else if (saturate)
            r.sum = (s > hi) ? hi : lo;
        else
            r.sum = (s <<< (64 - width)) >>> (64 - width);
        return r;
    endfunction

endpackage

// File: rtl/skew_accum_column.sv
// rtl/skew_accum_column.sv - one column of row accumulators with its skew control stage
module skew_accum_column
    import skew_accum_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 40,
    parameter int SATURATE  = 1,
    localparam int RW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  skew_ctl_t            ctl_in,
    input  logic [IN_WIDTH-1:0]  data,
    input  logic [RW-1:0]        rd_ptr,
    input  logic                 ovf_clr,
    output skew_ctl_t            ctl_out,
    output logic [ACC_WIDTH-1:0] rd_data,
    output logic                 ovf
);

    logic [ACC_WIDTH-1:0] acc_mem [DEPTH];
    logic [ACC_WIDTH-1:0] cur;
    logic [ACC_WIDTH-1:0] ext_data;
    logic [ACC_WIDTH-1:0] nxt;
    sat_res_t             res;
    logic                 add_ovf;

    always_comb begin
        cur = '0;
        for (int r = 0; r < DEPTH; r++) begin
            if (ctl_in.row == ROW_W_MAX'(r))
                cur = acc_mem[r];
        end
        ext_data = ACC_WIDTH'($signed(data));
        res      = sat_add(64'($signed(cur)), 64'($signed(data)), ACC_WIDTH, SATURATE != 0);
        nxt      = ctl_in.init ? ext_data : res.sum[ACC_WIDTH-1:0];
        add_ovf  = ctl_in.valid && !ctl_in.init && res.ovf;
    end

    // Storage is deliberately left unreset; the first beat of a row carries init.
    always_ff @(posedge clk) begin
        if (!rst && ctl_in.valid) begin
            for (int r = 0; r < DEPTH; r++) begin
                if (ctl_in.row == ROW_W_MAX'(r))
                    acc_mem[r] <= nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_out <= '0;
            ovf     <= 1'b0;
        end else begin
            ctl_out <= ctl_in;
            if (ovf_clr)
                ovf <= 1'b0;
            else if (add_ovf)
                ovf <= 1'b1;
        end
    end

    assign rd_data = acc_mem[rd_ptr];

endmodule

// File: rtl/skew_accum_bank.sv
// rtl/skew_accum_bank.sv - column-skewed partial-sum accumulator bank with row-wise drain
module skew_accum_bank
    import skew_accum_pkg::*;
#(
    parameter int SIZE      = 16,
    parameter int DEPTH     = 16,
    parameter int IN_WIDTH  = 32,
    parameter int ACC_WIDTH = 40,
    parameter int SATURATE  = 1,
    localparam int RW       = $clog2(DEPTH),
    localparam int CW       = $clog2(SIZE)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SIZE-1:0][IN_WIDTH-1:0]   data_in,
    input  logic                            in_valid_i,
    input  logic                            in_init_i,
    input  logic                            in_last_i,
    output logic                            in_ready_o,
    output logic [SIZE-1:0][ACC_WIDTH-1:0]  out_data_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [RW-1:0]                   out_row_o,
    output logic                            out_last_o,
    output logic                            ovf_o,
    output logic                            tile_done_o,
    output logic                            busy_o
);

    state_t          state_q;
    state_t          state_d;
    logic [RW-1:0]   wr_ptr;
    logic [RW-1:0]   rd_ptr;
    logic [CW-1:0]   flush_cnt;
    logic            accept;
    logic            drain_hs;
    logic            drain_end;
    skew_ctl_t       ctl [SIZE+1];
    logic [SIZE-1:0] col_ovf;

    assign accept    = in_valid_i && in_ready_o;
    assign drain_hs  = out_valid_o && out_ready_i;
    assign drain_end = drain_hs && (rd_ptr == RW'(DEPTH - 1));

    assign ctl[0] = '{valid: accept, init: in_init_i, row: ROW_W_MAX'(wr_ptr)};

    // Column i sees the beat i cycles after column 0, matching the upstream data skew.
    for (genvar i = 0; i < SIZE; i++) begin : g_col
        skew_accum_column #(
            .DEPTH     (DEPTH),
            .IN_WIDTH  (IN_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .SATURATE  (SATURATE)
        ) u_col (
            .clk     (clk),
            .rst     (rst),
            .ctl_in  (ctl[i]),
            .data    (data_in[i]),
            .rd_ptr  (rd_ptr),
            .ovf_clr (drain_end),
            .ctl_out (ctl[i+1]),
            .rd_data (out_data_o[i]),
            .ovf     (col_ovf[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ACCUM;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: if (accept && in_last_i && (wr_ptr == RW'(DEPTH - 1))) state_d = FLUSH;
            FLUSH: if (flush_cnt == CW'(SIZE - 2)) state_d = DRAIN;
            DRAIN: if (drain_end) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == ACCUM);
        out_valid_o = (state_q == DRAIN);
        busy_o      = (state_q != ACCUM);
        out_last_o  = out_valid_o && (rd_ptr == RW'(DEPTH - 1));
    end

    // The flush counter lets the last beat ripple through every column before draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            flush_cnt   <= '0;
            tile_done_o <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            flush_cnt <= (state_q == FLUSH) ? flush_cnt + 1'b1 : '0;
            if (drain_hs)
                rd_ptr <= rd_ptr + 1'b1;
            tile_done_o <= drain_end;
        end
    end

    assign out_row_o = rd_ptr;
    assign ovf_o     = |col_ovf;

endmodule

// File: tb/tb_skew_accum_bank.sv
// tb/tb_skew_accum_bank.sv - self-checking bench for skew_accum_bank against a row-level model
module tb_skew_accum_bank;

    localparam int SZ = 4;
    localparam int DP = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [SZ-1:0][15:0]  data_in;
    logic                 in_valid_i, in_init_i, in_last_i, out_ready_i;

    logic                 in_ready_o, out_valid_o, out_last_o, ovf_o, tile_done_o, busy_o;
    logic [SZ-1:0][31:0]  out_data_o;
    logic [1:0]           out_row_o;

    logic                 in_ready_s, out_valid_s, out_last_s, ovf_s, tile_done_s, busy_s;
    logic [SZ-1:0][16:0]  out_data_s;
    logic [1:0]           out_row_s;

    logic                 in_ready_w, out_valid_w, out_last_w, ovf_w, tile_done_w, busy_w;
    logic [SZ-1:0][16:0]  out_data_w;
    logic [1:0]           out_row_w;

    skew_accum_bank #(.SIZE(SZ), .DEPTH(DP), .IN_WIDTH(16), .ACC_WIDTH(32), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid_i(in_valid_i), .in_init_i(in_init_i),
        .in_last_i(in_last_i), .in_ready_o(in_ready_o), .out_data_o(out_data_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_row_o(out_row_o),
        .out_last_o(out_last_o), .ovf_o(ovf_o), .tile_done_o(tile_done_o), .busy_o(busy_o));

    skew_accum_bank #(.SIZE(SZ), .DEPTH(DP), .IN_WIDTH(16), .ACC_WIDTH(17), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid_i(in_valid_i), .in_init_i(in_init_i),
        .in_last_i(in_last_i), .in_ready_o(in_ready_s), .out_data_o(out_data_s),
        .out_valid_o(out_valid_s), .out_ready_i(out_ready_i), .out_row_o(out_row_s),
        .out_last_o(out_last_s), .ovf_o(ovf_s), .tile_done_o(tile_done_s), .busy_o(busy_s));

    skew_accum_bank #(.SIZE(SZ), .DEPTH(DP), .IN_WIDTH(16), .ACC_WIDTH(17), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .data_in(data_in), .in_valid_i(in_valid_i), .in_init_i(in_init_i),
        .in_last_i(in_last_i), .in_ready_o(in_ready_w), .out_data_o(out_data_w),
        .out_valid_o(out_valid_w), .out_ready_i(out_ready_i), .out_row_o(out_row_w),
        .out_last_o(out_last_w), .ovf_o(ovf_w), .tile_done_o(tile_done_w), .busy_o(busy_w));

    // Model: whole rows are applied at once; the skew is only a driver concern.
    bit     m_ready, m_done, chk_en;
    int     m_wr, m_rd, m_drain_at, cyc;
    bit     m_ovf [3];
    longint m_acc [3][DP][SZ];
    int     cur [SZ];
    int     h [SZ][SZ];
    int     checks, failures;

    function automatic int wd(input int k);
        return (k == 0) ? 32 : 17;
    endfunction

    function automatic bit sat(input int k);
        return k != 2;
    endfunction

    function automatic longint arith(input longint a, input longint d, input int w, input bit s,
                                     output bit o);
        longint sum, hi, lo;
        sum = a + d;
        hi  = (longint'(1) << (w - 1)) - 1;
        lo  = -hi - 1;
        o   = (sum > hi) || (sum < lo);
        if (!o) return sum;
        if (s) return (sum > hi) ? hi : lo;
        return (sum > hi) ? sum - (longint'(1) << w) : sum + (longint'(1) << w);
    endfunction

    function automatic bit m_valid();
        return !m_ready && (cyc >= m_drain_at);
    endfunction

    task automatic chk(input string nm, input logic signed [63:0] got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic step(input bit v, input bit ini, input bit lst);
        bit pv, o;
        for (int k = SZ - 1; k > 0; k--)
            for (int i = 0; i < SZ; i++) h[k][i] = h[k-1][i];
        for (int i = 0; i < SZ; i++) h[0][i] = cur[i];
        for (int i = 0; i < SZ; i++) data_in[i] = 16'(h[i][i]);
        in_valid_i = v;
        in_init_i  = ini;
        in_last_i  = lst;
        @(posedge clk);
        pv = m_valid();
        if (rst) begin
            m_ready = 1; m_wr = 0; m_rd = 0; m_done = 0;
            for (int k = 0; k < 3; k++) m_ovf[k] = 0;
        end else begin
            m_done = 0;
            if (v && m_ready) begin
                for (int k = 0; k < 3; k++)
                    for (int i = 0; i < SZ; i++) begin
                        if (ini)
                            m_acc[k][m_wr][i] = cur[i];
                        else begin
                            m_acc[k][m_wr][i] = arith(m_acc[k][m_wr][i], cur[i], wd(k), sat(k), o);
                            if (o) m_ovf[k] = 1;
                        end
                    end
                if (lst && m_wr == DP - 1) begin
                    m_ready    = 0;
                    m_drain_at = cyc + SZ;
                end
                m_wr = (m_wr + 1) % DP;
            end
            if (pv && out_ready_i) begin
                if (m_rd == DP - 1) begin
                    m_rd = 0; m_ready = 1; m_done = 1;
                    for (int k = 0; k < 3; k++) m_ovf[k] = 0;
                end else
                    m_rd++;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic drain(input bit pat, input bit noise);
        bit pat_arr [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
        int pi = 0;
        int b  = 0;
        while (!m_ready && b < 60) begin
            out_ready_i = (pat && m_valid()) ? pat_arr[pi % 8] : 1'b1;
            if (pat && m_valid()) pi++;
            for (int i = 0; i < SZ; i++) cur[i] = 999;
            step(noise && b[0], 1, 1);
            b++;
        end
        chk("drain_complete", in_ready_o, 1);
        out_ready_i = 1;
    endtask

    task automatic init_tile(input int kind);
        for (int r = 0; r < DP; r++) begin
            for (int i = 0; i < SZ; i++)
                cur[i] = (kind == 0) ? 10 * r + i : (kind == 1) ? i - 2 :
                         (kind == 2) ? 100 * r - 3 * i : (kind == 3) ? 7 * r - i : r + 50 * i;
            step(1, 1, r == DP - 1);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready_o, m_ready);
            chk("busy", busy_o, !m_ready);
            chk("out_valid", out_valid_o, m_valid());
            chk("out_valid_s", out_valid_s, m_valid());
            chk("out_valid_w", out_valid_w, m_valid());
            chk("tile_done", tile_done_o, m_done);
            if (m_valid()) begin
                chk("out_row", out_row_o, m_rd);
                chk("out_last", out_last_o, m_rd == DP - 1);
                chk("ovf", ovf_o, m_ovf[0]);
                chk("ovf_s", ovf_s, m_ovf[1]);
                chk("ovf_w", ovf_w, m_ovf[2]);
                for (int c = 0; c < SZ; c++) begin
                    chk($sformatf("data_c%0d", c), $signed(out_data_o[c]), m_acc[0][m_rd][c]);
                    chk($sformatf("data_s_c%0d", c), $signed(out_data_s[c]), m_acc[1][m_rd][c]);
                    chk($sformatf("data_w_c%0d", c), $signed(out_data_w[c]), m_acc[2][m_rd][c]);
                end
            end
        end
    end

    initial begin
        int b;
        checks = 0; failures = 0; chk_en = 0; cyc = 0; m_drain_at = 0;
        rst = 1; in_valid_i = 0; in_init_i = 0; in_last_i = 0; out_ready_i = 1;
        for (int i = 0; i < SZ; i++) begin
            cur[i] = 0;
            for (int k = 0; k < SZ; k++) h[k][i] = 0;
        end
        step(0, 0, 0);
        step(0, 0, 0);
        rst = 0;
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_tile_done", tile_done_o, 0);
        chk_en = 1;

        init_tile(0);
        chk("pin_t1", m_acc[0][2][3], 23);
        drain(0, 0);

        for (int p = 0; p < 3; p++)
            for (int r = 0; r < DP; r++) begin
                for (int i = 0; i < SZ; i++) cur[i] = 5;
                if (p == 2) cur[2] = -7;
                step(1, p == 0, (p == 2 && r == DP - 1) || (p == 0 && r == 1));
            end
        chk("pin_t2_15", m_acc[0][1][0], 15);
        chk("pin_t2_3", m_acc[0][3][2], 3);
        drain(0, 1);

        for (int p = 0; p < 3; p++)
            for (int r = 0; r < DP; r++) begin
                for (int i = 0; i < SZ; i++) cur[i] = 32767;
                step(1, p == 0, p == 2 && r == DP - 1);
            end
        chk("pin_sat", m_acc[1][0][0], 65535);
        chk("pin_wrap", m_acc[2][3][1], -32771);
        chk("pin_ovf_s", m_ovf[1], 1);
        chk("pin_main_sum", m_acc[0][2][2], 98301);
        drain(0, 0);
        init_tile(1);
        drain(0, 0);

        init_tile(2);
        drain(1, 0);

        init_tile(3);
        b = 0;
        while (!(m_valid() && m_rd == 1) && b < 40) begin
            step(0, 0, 0);
            b++;
        end
        chk("t6_at_row1", out_row_o, 1);
        rst = 1;
        step(0, 0, 0);
        rst = 0;
        chk("t6_out_valid", out_valid_o, 0);
        chk("t6_in_ready", in_ready_o, 1);
        chk("t6_busy", busy_o, 0);
        init_tile(4);
        drain(0, 0);

        step(0, 0, 0);
        step(0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
